// File: rtl/dt_pack_if.sv
// Memory-side bus of dt_pack: result-map read port and packed-image write port.
// master = packer side, slave = memory side.
interface dt_pack_if #(
   parameter int PIX_W = 8
);
   logic             res_rd;
   logic [13:0]      res_addr;
   logic [PIX_W-1:0] res_di;
   logic             sti_wr;
   logic [9:0]       sti_addr;
   logic [15:0]      sti_do;

   modport master (
      output res_rd, res_addr, sti_wr, sti_addr, sti_do,
      input  res_di
   );

   modport slave (
      input  res_rd, res_addr, sti_wr, sti_addr, sti_do,
      output res_di
   );
endinterface

// File: rtl/dt_pack.sv
// Thresholds the 8-bit result map and packs 16 pixels MSB-first per 16-bit word.
// Optional object-pixel counter on obj_cnt when DT_PACK_CNT_EN is defined.
module dt_pack #(
   parameter int PIX_W     = 8,
   parameter int IMG_WORDS = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PIX_W-1:0] thr,
   output logic             busy,
   output logic             done,
   dt_pack_if.master        bus
`ifdef DT_PACK_CNT_EN
   ,
   output logic [14:0]      obj_cnt
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]       state_q,    state_d;
   logic [PIX_W-1:0] thr_q,      thr_d;
   logic [13:0]      pix_cnt_q,  pix_cnt_d;
   logic [9:0]       word_cnt_q, word_cnt_d;
   logic [15:0]      shreg_q,    shreg_d;
   logic             pix_bit;

`ifdef DT_PACK_CNT_EN
   logic [14:0]      obj_cnt_q,  obj_cnt_d;
   assign obj_cnt = obj_cnt_q;
`endif

   assign pix_bit = (bus.res_di > thr_q);

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign bus.res_rd   = (state_q == READ);
   assign bus.res_addr = (state_q == READ)  ? pix_cnt_q  : 14'd0;
   assign bus.sti_wr   = (state_q == WRITE);
   assign bus.sti_addr = (state_q == WRITE) ? word_cnt_q : 10'd0;
   assign bus.sti_do   = (state_q == WRITE) ? shreg_q    : 16'd0;

   always_comb begin
      state_d    = state_q;
      thr_d      = thr_q;
      pix_cnt_d  = pix_cnt_q;
      word_cnt_d = word_cnt_q;
      shreg_d    = shreg_q;
`ifdef DT_PACK_CNT_EN
      obj_cnt_d  = obj_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               thr_d      = thr;
               pix_cnt_d  = 14'd0;
               word_cnt_d = 10'd0;
               shreg_d    = 16'd0;
`ifdef DT_PACK_CNT_EN
               obj_cnt_d  = 15'd0;
`endif
               state_d    = READ;
            end
         end
         READ: begin
            // Earlier pixels shift toward the MSB, so pixel k of a word ends in bit 15-k.
            shreg_d   = {shreg_q[14:0], pix_bit};
            pix_cnt_d = pix_cnt_q + 14'd1;
`ifdef DT_PACK_CNT_EN
            obj_cnt_d = obj_cnt_q + {14'd0, pix_bit};
`endif
            if (pix_cnt_q[3:0] == 4'hF) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            word_cnt_d = word_cnt_q + 10'd1;
            if (word_cnt_q == 10'(IMG_WORDS - 1)) begin
               state_d = DONE;
            end else begin
               state_d = READ;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         thr_q      <= '0;
         pix_cnt_q  <= 14'd0;
         word_cnt_q <= 10'd0;
         shreg_q    <= 16'd0;
`ifdef DT_PACK_CNT_EN
         obj_cnt_q  <= 15'd0;
`endif
      end else begin
         state_q    <= state_d;
         thr_q      <= thr_d;
         pix_cnt_q  <= pix_cnt_d;
         word_cnt_q <= word_cnt_d;
         shreg_q    <= shreg_d;
`ifdef DT_PACK_CNT_EN
         obj_cnt_q  <= obj_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_dt_pack.sv
// Directed bench for dt_pack: full frames with hand-computed packed words,
// ignored restarts, threshold toggling and mid-frame reset.
module tb_dt_pack;

   localparam int FRAME_WORDS = 1024;
   localparam int FRAME_PIX   = 16384;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  thr;
   logic        busy;
   logic        done;
`ifdef DT_PACK_CNT_EN
   logic [14:0] obj_cnt;
`endif

   logic [7:0]  res_mem [FRAME_PIX];

   dt_pack_if #(.PIX_W(8)) bus ();

   dt_pack #(.PIX_W(8), .IMG_WORDS(FRAME_WORDS)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .thr     (thr),
      .busy    (busy),
      .done    (done),
      .bus     (bus.master)
`ifdef DT_PACK_CNT_EN
      ,
      .obj_cnt (obj_cnt)
`endif
   );

   assign bus.res_di = res_mem[bus.res_addr];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // Per-frame observations gathered by the monitor below.
   int          wr_cnt, rd_cnt, addr_err, data_err, rd_err, idle_err, overlap_err;
   int          done_cnt, done_cyc, first_wr_cyc, last_wr_cyc;
   logic [15:0] exp_w0, exp_rest;
   logic [9:0]  exp_addr;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor sampling on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (bus.sti_wr) begin
         if (wr_cnt == 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         wr_cnt++;
         if (bus.sti_addr !== exp_addr) addr_err++;
         if (bus.sti_do !== ((exp_addr == 10'd0) ? exp_w0 : exp_rest)) data_err++;
         exp_addr = exp_addr + 10'd1;
      end else if (bus.sti_addr !== 10'd0 || bus.sti_do !== 16'd0) begin
         idle_err++;
      end
      if (bus.res_rd) begin
         if (bus.res_addr !== 14'(rd_cnt)) rd_err++;
         rd_cnt++;
      end else if (bus.res_addr !== 14'd0) begin
         idle_err++;
      end
      if (bus.res_rd && bus.sti_wr) overlap_err++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic clearStats();
      wr_cnt = 0; rd_cnt = 0; addr_err = 0; data_err = 0; rd_err = 0;
      idle_err = 0; overlap_err = 0; done_cnt = 0; done_cyc = 0;
      first_wr_cyc = 0; last_wr_cyc = 0; exp_addr = 10'd0;
   endtask

   task automatic applyStimulus(input string name, input logic [7:0] thr_v,
                                input logic [15:0] w0, input logic [15:0] rest,
                                input int restart_at, input bit toggle,
                                input int exp_obj);
      int  t0;
      bit  seen;
      @(posedge clk);
      clearStats();
      exp_w0   = w0;
      exp_rest = rest;
      @(negedge clk);
      start = 1'b1;
      thr   = thr_v;
      t0    = cyc;
      @(negedge clk);
      start = 1'b0;
      if (toggle) thr = ~thr;
      checkOutput({name, "_busy_t1"}, {31'd0, busy}, 32'd1);
      checkOutput({name, "_rd_t1"}, {31'd0, bus.res_rd}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 17500 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            checkOutput({name, "_busy_at_done"}, {31'd0, busy}, 32'd1);
         end
         start = (restart_at != 0 && cyc == t0 + restart_at);
         if (start) thr = ~thr_v;
         else if (toggle) thr = ~thr;
      end
      start = 1'b0;
      if (!seen) checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
      repeat (4) @(negedge clk);
      checkOutput({name, "_writes"}, wr_cnt, FRAME_WORDS);
      checkOutput({name, "_reads"}, rd_cnt, FRAME_PIX);
      checkOutput({name, "_addr_errs"}, addr_err, 0);
      checkOutput({name, "_data_errs"}, data_err, 0);
      checkOutput({name, "_rdaddr_errs"}, rd_err, 0);
      checkOutput({name, "_idle_errs"}, idle_err, 0);
      checkOutput({name, "_overlap"}, overlap_err, 0);
      checkOutput({name, "_done_count"}, done_cnt, 1);
      checkOutput({name, "_first_wr"}, first_wr_cyc - t0, 17);
      checkOutput({name, "_last_wr"}, last_wr_cyc - t0, 17408);
      checkOutput({name, "_done_cyc"}, done_cyc - t0, 17409);
      checkOutput({name, "_busy_after"}, {31'd0, busy}, 32'd0);
`ifdef DT_PACK_CNT_EN
      checkOutput({name, "_obj_cnt"}, {17'd0, obj_cnt}, exp_obj);
`else
      if (exp_obj < 0) $display("[TB] negative object count requested");
`endif
   endtask

   task automatic checkIdleOutputs(input string name);
      checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({name, "_done"}, {31'd0, done}, 32'd0);
      checkOutput({name, "_res_rd"}, {31'd0, bus.res_rd}, 32'd0);
      checkOutput({name, "_res_addr"}, {18'd0, bus.res_addr}, 32'd0);
      checkOutput({name, "_sti_wr"}, {31'd0, bus.sti_wr}, 32'd0);
      checkOutput({name, "_sti_addr"}, {22'd0, bus.sti_addr}, 32'd0);
      checkOutput({name, "_sti_do"}, {16'd0, bus.sti_do}, 32'd0);
`ifdef DT_PACK_CNT_EN
      checkOutput({name, "_obj_cnt"}, {17'd0, obj_cnt}, 32'd0);
`endif
   endtask

   initial begin
      int t0;
      reset = 1'b1;
      start = 1'b0;
      thr   = 8'd0;
      clearStats();
      exp_w0 = 16'd0;
      exp_rest = 16'd0;
      for (int i = 0; i < FRAME_PIX; i++) res_mem[i] = 8'd0;
      repeat (3) @(negedge clk);
      checkIdleOutputs("reset");
      reset = 1'b0;

      applyStimulus("zero", 8'd0, 16'h0000, 16'h0000, 0, 1'b0, 0);

      // Word 0 holds pixel values 0..15; everything else stays zero.
      for (int i = 0; i < 16; i++) res_mem[i] = 8'(i);
      applyStimulus("ramp_thr0_restart", 8'd0, 16'h7FFF, 16'h0000, 100, 1'b0, 15);
      applyStimulus("ramp_thr7_toggle", 8'd7, 16'h00FF, 16'h0000, 0, 1'b1, 8);

      for (int i = 0; i < FRAME_PIX; i++) res_mem[i] = 8'hFF;
      @(negedge clk);
      start = 1'b1;
      thr   = 8'hFE;
      t0    = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < t0 + 500) @(negedge clk);
      checkOutput("midframe_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      checkIdleOutputs("midreset");
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checkOutput("start_lost_in_reset", {31'd0, busy}, 32'd0);

      applyStimulus("ones_after_reset", 8'hFE, 16'hFFFF, 16'hFFFF, 0, 1'b0, 16384);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
